// File: rtl/fetch_queue.sv
// FetchQueue: decoupling instruction buffer between IF and ID.
// Holds {pc, instr} pairs in a circular buffer and presents the oldest entry
// show-ahead to ID. A taken branch (flush) discards every queued entry.
// in_ready feeds IF's pc_write, so the PC stops advancing only when the queue is full.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_pc_plus4,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XLEN-1:0] NopInstr = XLEN'(32'h0000_0013);

  logic [XLEN-1:0] pcMem_q    [DEPTH];
  logic [XLEN-1:0] instrMem_q [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;

  logic doPush;
  logic doPop;

  // Handshake qualification; ready/valid come from registered occupancy only,
  // so there is no combinational path from out_ready to in_ready.
  always_comb begin
    in_ready  = (count_q != CW'(DEPTH));
    out_valid = (count_q != '0);
    doPush    = in_valid & in_ready & ~flush;
    doPop     = out_valid & out_ready & ~flush;
  end

  // Next pointer and occupancy values; flush returns the queue to empty.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + AW'(1);
      if (doPop)  rdPtr_d = rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset wins over flush and handshakes.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately not reset; only accepted pushes write it.
  always_ff @(posedge clk) begin
    if (!reset && doPush) begin
      pcMem_q[wrPtr_q]    <= in_pc;
      instrMem_q[wrPtr_q] <= in_instr;
    end
  end

  // Show-ahead head entry; an empty queue presents a harmless NOP at pc 0.
  always_comb begin
    out_pc    = '0;
    out_instr = NopInstr;
    if (count_q != '0) begin
      out_pc    = pcMem_q[rdPtr_q];
      out_instr = instrMem_q[rdPtr_q];
    end
    out_pc_plus4 = out_pc + XLEN'(4);
    count        = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: one task per scenario, inline checks.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_instr;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_pc_plus4;
  logic [XLEN-1:0] out_instr;
  logic [2:0]      count;

  int errors = 0;
  int checks = 0;

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .out_instr(out_instr), .count(count)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    step(); step();
    reset = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_instr !== 32'h0000_0013) begin errors++; $display("[TB] FAIL reset_out_instr: got %h expected 00000013", out_instr); end
    checks++; if (out_pc_plus4 !== 32'd4) begin errors++; $display("[TB] FAIL reset_pc_plus4: got %h expected 00000004", out_pc_plus4); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_pc: got %h expected 00000000", out_pc); end
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'(i * 4); in_instr = 32'hA000_0000 | 32'(i);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL fill_in_ready%0d: got %b expected 1", i, in_ready); end
      step();
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_ready: got %b expected 0", in_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_count: got %0d expected 4", count); end
    in_pc = 32'd16; in_instr = 32'hA000_0004;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL fill_refused_count: got %0d expected 4", count); end
    checks++; if (out_pc !== 32'd0) begin errors++; $display("[TB] FAIL fill_head_pc: got %h expected 00000000", out_pc); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_refused_ready: got %b expected 0", in_ready); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL drain_valid%0d: got %b expected 1", i, out_valid); end
      checks++; if (out_pc !== 32'(i * 4)) begin errors++; $display("[TB] FAIL drain_pc%0d: got %h expected %h", i, out_pc, 32'(i * 4)); end
      checks++; if (out_pc_plus4 !== 32'(i * 4 + 4)) begin errors++; $display("[TB] FAIL drain_plus4_%0d: got %h expected %h", i, out_pc_plus4, 32'(i * 4 + 4)); end
      checks++; if (out_instr !== (32'hA000_0000 | 32'(i))) begin errors++; $display("[TB] FAIL drain_instr%0d: got %h expected %h", i, out_instr, 32'hA000_0000 | 32'(i)); end
      if (i == 1) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_ready_rise: got %b expected 1", in_ready); end
      end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_empty_valid: got %b expected 0", out_valid); end
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL drain_empty_count: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(k * 4); in_instr = 32'hB000_0000 | 32'(k);
      if (k == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_first_valid: got %b expected 0", out_valid); end
      end else begin
        checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL stream_count%0d: got %0d expected 1", k, count); end
        checks++; if (out_pc !== 32'h200 + 32'((k - 1) * 4)) begin errors++; $display("[TB] FAIL stream_pc%0d: got %h expected %h", k, out_pc, 32'h200 + 32'((k - 1) * 4)); end
        checks++; if (out_instr !== (32'hB000_0000 | 32'(k - 1))) begin errors++; $display("[TB] FAIL stream_instr%0d: got %h expected %h", k, out_instr, 32'hB000_0000 | 32'(k - 1)); end
      end
      step();
    end
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h24C) begin errors++; $display("[TB] FAIL stream_last_pc: got %h expected 0000024c", out_pc); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL stream_drained: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h10 + 32'(i * 4); in_instr = 32'hC000_0000 | 32'(i);
      step();
    end
    checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL flush_pre_count: got %0d expected 3", count); end
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40; in_instr = 32'hDEAD_0040; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_in_ready: got %b expected 1", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL flush_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_instr !== 32'h0000_0013) begin errors++; $display("[TB] FAIL flush_nop: got %h expected 00000013", out_instr); end
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hCAFE_0100;
    step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h100) begin errors++; $display("[TB] FAIL flush_target_pc: got %h expected 00000100", out_pc); end
    checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL flush_target_count: got %0d expected 1", count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL flush_no_stale: got %0d expected 0", count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h80 + 32'(i * 4); in_instr = 32'hE000_0000 | 32'(i);
      step();
    end
    checks++; if (count !== 3'd2) begin errors++; $display("[TB] FAIL rmid_pre_count: got %0d expected 2", count); end
    reset = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h88; out_ready = 1'b1;
    step();
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL rmid_count: got %0d expected 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_out_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rmid_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_instr !== 32'h0000_0013) begin errors++; $display("[TB] FAIL rmid_nop: got %h expected 00000013", out_instr); end
    checks++; if (out_pc_plus4 !== 32'd4) begin errors++; $display("[TB] FAIL rmid_plus4: got %h expected 00000004", out_pc_plus4); end
    in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'hF000_0300;
    step();
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h300) begin errors++; $display("[TB] FAIL rmid_push_pc: got %h expected 00000300", out_pc); end
    checks++; if (out_pc_plus4 !== 32'h304) begin errors++; $display("[TB] FAIL rmid_push_plus4: got %h expected 00000304", out_pc_plus4); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
